ste_bus_arbiter: RTL and testbench
==================================

Name: ste_bus_arbiter

Overview:
68000-style bus arbiter for the STE system bus. It replaces the single-flop BG generator between the MCU DMA and the CPU and shares the bus between two alternate masters: the MCU DMA (FDC/ACSI) and the blitter. It implements the BR/BG/BGACK handshake, fixed priority with a CPU fairness gap for the blitter, and a grant timeout. It also drives bus_free, which the shifter, DMA and CPU wrappers use.

Parameters:
GRANT_TIMEOUT, 16, number of clk_en ticks BG may stay asserted without BGACK before the grant is withdrawn.
BLT_GAP, 4, minimum clk_en ticks of CPU ownership after a blitter tenure before the blitter can be granted again.

Ports:
clk32  input  1  system clock, 32 MHz.
reset  input  1  synchronous active-high reset.
clk_en  input  1  8 MHz bus-phase enable (MHZ8_EN1); all state changes happen only on cycles where clk_en=1.
as_n  input  1  CPU address strobe, active low.
dma_br_n  input  1  DMA bus request (gstmcu BR_N_O), active low.
dma_bgack_n  input  1  DMA bus grant acknowledge (gstmcu BGACK_N_O), active low.
blt_br_n  input  1  blitter bus request, active low.
blt_bgack_n  input  1  blitter bus grant acknowledge, active low.
dma_bg_n  output  1  bus grant to DMA, active low.
blt_bg_n  output  1  bus grant to blitter, active low.
bus_owner  output  2  0=CPU, 1=DMA, 2=blitter; 3 is never driven.
bus_free  output  1  1 when the CPU may run bus cycles (no grant outstanding and no BGACK asserted).
grant_timeout  output  1  one clk32 pulse when a grant is withdrawn by timeout.

Behaviour:
- All outputs and state are registered.
- On reset: state=IDLE, dma_bg_n=1, blt_bg_n=1, bus_owner=0, bus_free=1, grant_timeout=0, timeout counter=0, gap counter=0. Reset overrides everything, including mid-tenure; a master still holding BGACK after reset is handled by the OWNED entry rule below.
- Counters are 5-bit and saturate; they do not wrap. The timeout counter counts up; the gap counter counts down to 0.
- State machine. Each transition happens at clk32 when clk_en=1.
  IDLE:
    - If dma_bgack_n=0 or blt_bgack_n=0: go to OWNED with owner = the master asserting BGACK (DMA wins if both).
    - Else, if as_n=1 and a request is pending: go to GRANT and assert that master's BG on the same edge.
    - Arbitration: DMA first; blitter only if its gap counter=0. Gap counter decrements each tick while in IDLE.
    - If as_n=0, the grant is deferred until a tick with as_n=1. The CPU cycle is never split.
  GRANT:
    - Exactly one BG is low. Timeout counter increments each tick.
    - If the granted master's BGACK=0: go to OWNED, release BG (BG=1), set bus_owner.
    - Else, if the granted master's BR=1 (request withdrawn): release BG, go to IDLE.
    - Else, if timeout counter = GRANT_TIMEOUT-1: release BG, pulse grant_timeout, go to IDLE.
    - A higher-priority request arriving in GRANT does not preempt.
  OWNED:
    - Both BG high; bus_owner = owner.
    - When the owner's BGACK=1: go to IDLE, bus_owner=0, timeout counter=0. If the owner was the blitter, load the gap counter with BLT_GAP.
    - The next grant is evaluated at the earliest on the following tick.
- bus_free = (state==IDLE) and both BGACK high, registered.
  - Goes low on the edge BG asserts.
  - Goes high one tick after the owner releases BGACK.
- Simultaneous BR from DMA and blitter in IDLE: DMA is granted.
- A BGACK from a non-granted master during GRANT is ignored until OWNED ends. Verification flags it as a protocol error.
- clk_en=0: all state, counters and outputs hold.

Test Plan:
1. Reset, then dma_br_n=0 with as_n=1. dma_bg_n goes low on the next clk_en edge and bus_free=0. After dma_bgack_n=0, on the next tick dma_bg_n=1 and bus_owner=1. After dma_bgack_n=1, on the next tick bus_owner=0 and bus_free=1.
2. blt_br_n=0 while as_n=0 for 3 ticks. No grant is issued. blt_bg_n goes low on the first tick with as_n=1.
3. dma_br_n and blt_br_n fall in the same tick. dma_bg_n=0 and blt_bg_n stays 1. The blitter is granted after the DMA tenure ends.
4. A blitter tenure ends while blt_br_n stays 0. No blitter grant is issued for BLT_GAP=4 ticks; blt_bg_n falls on the tick after the gap counter reaches 0. A DMA request during the gap is granted immediately.
5. Grant to the DMA, which never acknowledges. On tick 16 dma_bg_n returns to 1, grant_timeout pulses for one clk32, and state returns to IDLE.
6. reset asserted during a DMA OWNED tenure with dma_bgack_n held at 0. Outputs take their reset values on that edge. On the next clk_en, IDLE sees the BGACK and enters OWNED with bus_owner=1 and bus_free=0.

Source files
------------

// File: rtl/ste_bus_arbiter_if.sv
// STE system bus arbitration signals.
// slave = arbiter side, master = requesting bus masters.
interface ste_bus_arbiter_if;
  logic       as_n;
  logic       dma_br_n;
  logic       dma_bgack_n;
  logic       blt_br_n;
  logic       blt_bgack_n;
  logic       dma_bg_n;
  logic       blt_bg_n;
  logic [1:0] bus_owner;
  logic       bus_free;
  logic       grant_timeout;

  modport slave (
    input  as_n,
    input  dma_br_n,
    input  dma_bgack_n,
    input  blt_br_n,
    input  blt_bgack_n,
    output dma_bg_n,
    output blt_bg_n,
    output bus_owner,
    output bus_free,
    output grant_timeout
  );

  modport master (
    output as_n,
    output dma_br_n,
    output dma_bgack_n,
    output blt_br_n,
    output blt_bgack_n,
    input  dma_bg_n,
    input  blt_bg_n,
    input  bus_owner,
    input  bus_free,
    input  grant_timeout
  );
endinterface

// File: rtl/ste_bus_arbiter.sv
// 68000-style BR/BG/BGACK arbiter for the STE bus:
// DMA over blitter, blitter CPU gap, grant timeout.
module ste_bus_arbiter #(
  parameter int GRANT_TIMEOUT = 16,
  parameter int BLT_GAP       = 4
) (
  input  logic              clk32,
  input  logic              reset,
  input  logic              clk_en,
  ste_bus_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    OWNED = 2'd2
  } state_e;

  localparam logic [4:0] TMO_LAST = 5'(GRANT_TIMEOUT - 1);
  localparam logic [4:0] GAP_LOAD = 5'(BLT_GAP);

  state_e     state_q, state_d;
  logic       owner_q, owner_d;
  logic [4:0] tmo_q, tmo_d;
  logic [4:0] gap_q, gap_d;
  logic       dma_bg_q, dma_bg_d;
  logic       blt_bg_q, blt_bg_d;
  logic [1:0] own_q, own_d;
  logic       free_q, free_d;
  logic       to_q, to_d;

  // owner_q: 0 = DMA, 1 = blitter
  logic ack_n;
  logic req_n;
  assign ack_n = owner_q ? bus.blt_bgack_n : bus.dma_bgack_n;
  assign req_n = owner_q ? bus.blt_br_n : bus.dma_br_n;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    tmo_d    = tmo_q;
    gap_d    = gap_q;
    dma_bg_d = dma_bg_q;
    blt_bg_d = blt_bg_q;
    own_d    = own_q;
    free_d   = free_q;
    to_d     = 1'b0;
    if (clk_en) begin
      unique case (state_q)
        IDLE: begin
          tmo_d = '0;
          if (gap_q != '0) gap_d = gap_q - 5'd1;
          if (!bus.dma_bgack_n || !bus.blt_bgack_n) begin
            state_d = OWNED;
            owner_d = bus.dma_bgack_n;
            own_d   = bus.dma_bgack_n ? 2'd2 : 2'd1;
          end else if (bus.as_n) begin
            if (!bus.dma_br_n) begin
              state_d  = GRANT;
              owner_d  = 1'b0;
              dma_bg_d = 1'b0;
            end else if (!bus.blt_br_n && gap_q == '0) begin
              state_d  = GRANT;
              owner_d  = 1'b1;
              blt_bg_d = 1'b0;
            end
          end
        end
        GRANT: begin
          if (tmo_q != 5'h1f) tmo_d = tmo_q + 5'd1;
          if (!ack_n) begin
            state_d  = OWNED;
            dma_bg_d = 1'b1;
            blt_bg_d = 1'b1;
            own_d    = owner_q ? 2'd2 : 2'd1;
          end else if (req_n) begin
            state_d  = IDLE;
            dma_bg_d = 1'b1;
            blt_bg_d = 1'b1;
          end else if (tmo_q == TMO_LAST) begin
            state_d  = IDLE;
            dma_bg_d = 1'b1;
            blt_bg_d = 1'b1;
            to_d     = 1'b1;
          end
        end
        OWNED: begin
          if (ack_n) begin
            state_d = IDLE;
            own_d   = 2'd0;
            tmo_d   = '0;
            if (owner_q) gap_d = GAP_LOAD;
          end
        end
        default: state_d = IDLE;
      endcase
      free_d = (state_d == IDLE) && bus.dma_bgack_n && bus.blt_bgack_n;
    end
  end

  always_ff @(posedge clk32) begin
    if (reset) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      tmo_q    <= '0;
      gap_q    <= '0;
      dma_bg_q <= 1'b1;
      blt_bg_q <= 1'b1;
      own_q    <= 2'd0;
      free_q   <= 1'b1;
      to_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      tmo_q    <= tmo_d;
      gap_q    <= gap_d;
      dma_bg_q <= dma_bg_d;
      blt_bg_q <= blt_bg_d;
      own_q    <= own_d;
      free_q   <= free_d;
      to_q     <= to_d;
    end
  end

  assign bus.dma_bg_n      = dma_bg_q;
  assign bus.blt_bg_n      = blt_bg_q;
  assign bus.bus_owner     = own_q;
  assign bus.bus_free      = free_q;
  assign bus.grant_timeout = to_q;

endmodule

// File: tb/tb_ste_bus_arbiter.sv
// Directed bench for ste_bus_arbiter.
// Output vector: {dma_bg_n, blt_bg_n, bus_owner, bus_free, grant_timeout}.
module tb_ste_bus_arbiter;

  localparam logic [5:0] IDLE_O = 6'b110010;
  localparam logic [5:0] DMA_G  = 6'b010000;
  localparam logic [5:0] DMA_O  = 6'b110100;
  localparam logic [5:0] BLT_G  = 6'b100000;
  localparam logic [5:0] BLT_O  = 6'b111000;
  localparam logic [5:0] TMO_O  = 6'b110011;

  logic clk32 = 1'b0;
  logic reset;
  logic clk_en;
  int   checks = 0;
  int   errors = 0;

  ste_bus_arbiter_if bus ();

  ste_bus_arbiter #(
    .GRANT_TIMEOUT(16),
    .BLT_GAP(4)
  ) dut (
    .clk32  (clk32),
    .reset  (reset),
    .clk_en (clk_en),
    .bus    (bus)
  );

  always #5 clk32 = ~clk32;

  function automatic logic [5:0] outs();
    return {bus.dma_bg_n, bus.blt_bg_n, bus.bus_owner,
            bus.bus_free, bus.grant_timeout};
  endfunction

  task automatic check(input string tag, input logic [5:0] exp);
    logic [5:0] obs;
    obs = outs();
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // one disabled clk32 cycle, then one enabled edge
  task automatic tick();
    clk_en = 1'b0;
    @(posedge clk32); #1;
    clk_en = 1'b1;
    @(posedge clk32); #1;
    clk_en = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk32); #1;
  endtask

  initial begin
    reset           = 1'b1;
    clk_en          = 1'b0;
    bus.as_n        = 1'b1;
    bus.dma_br_n    = 1'b1;
    bus.dma_bgack_n = 1'b1;
    bus.blt_br_n    = 1'b1;
    bus.blt_bgack_n = 1'b1;
    cyc();
    cyc();
    check("reset", IDLE_O);
    reset = 1'b0;

    // 1: DMA grant/own/release
    bus.dma_br_n = 1'b0;
    tick();
    check("t1_grant", DMA_G);
    bus.dma_bgack_n = 1'b0;
    bus.dma_br_n    = 1'b1;
    cyc();
    check("t1_hold_no_en", DMA_G);
    tick();
    check("t1_owned", DMA_O);
    bus.dma_bgack_n = 1'b1;
    tick();
    check("t1_release", IDLE_O);

    // 2: grant deferred while CPU strobes
    bus.as_n     = 1'b0;
    bus.blt_br_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t2_defer", IDLE_O);
    end
    bus.as_n = 1'b1;
    tick();
    check("t2_grant", BLT_G);
    bus.blt_bgack_n = 1'b0;
    bus.blt_br_n    = 1'b1;
    tick();
    check("t2_owned", BLT_O);
    bus.blt_bgack_n = 1'b1;
    tick();
    check("t2_release", IDLE_O);
    repeat (4) tick();

    // 3: simultaneous requests, DMA first
    bus.dma_br_n = 1'b0;
    bus.blt_br_n = 1'b0;
    tick();
    check("t3_dma_first", DMA_G);
    bus.dma_bgack_n = 1'b0;
    bus.dma_br_n    = 1'b1;
    tick();
    check("t3_dma_owned", DMA_O);
    bus.dma_bgack_n = 1'b1;
    tick();
    check("t3_dma_release", IDLE_O);
    tick();
    check("t3_blt_after", BLT_G);

    // 4: blitter CPU gap
    bus.blt_bgack_n = 1'b0;
    tick();
    check("t4_owned", BLT_O);
    bus.blt_bgack_n = 1'b1;
    tick();
    check("t4_release", IDLE_O);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t4_gap", IDLE_O);
    end
    tick();
    check("t4_regrant", BLT_G);
    bus.blt_bgack_n = 1'b0;
    tick();
    bus.blt_bgack_n = 1'b1;
    tick();
    check("t4_release2", IDLE_O);
    bus.dma_br_n = 1'b0;
    tick();
    check("t4_dma_in_gap", DMA_G);
    bus.blt_br_n    = 1'b1;
    bus.dma_bgack_n = 1'b0;
    bus.dma_br_n    = 1'b1;
    tick();
    bus.dma_bgack_n = 1'b1;
    tick();
    check("t4_dma_done", IDLE_O);

    // 5: grant timeout
    bus.dma_br_n = 1'b0;
    tick();
    check("t5_grant", DMA_G);
    repeat (15) tick();
    check("t5_tick15", DMA_G);
    tick();
    check("t5_timeout", TMO_O);
    bus.dma_br_n = 1'b1;
    cyc();
    check("t5_pulse_end", IDLE_O);

    // 6: reset mid-tenure with BGACK held
    bus.dma_br_n = 1'b0;
    tick();
    check("t6_grant", DMA_G);
    bus.dma_bgack_n = 1'b0;
    bus.dma_br_n    = 1'b1;
    tick();
    check("t6_owned", DMA_O);
    reset = 1'b1;
    cyc();
    check("t6_reset", IDLE_O);
    reset = 1'b0;
    tick();
    check("t6_reacquire", DMA_O);
    bus.dma_bgack_n = 1'b1;
    tick();
    check("t6_release", IDLE_O);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
